// File: rtl/clip_controller_if.sv
// Button/strobe inputs and memory/status outputs of the clip controller.
// master = controller side, slave = board/memory side.
interface clip_controller_if #(
  parameter int ADDR_W = 16
);
  logic              btn_record;
  logic              btn_play;
  logic              btn_clip;
  logic              sample_tick;
  logic              clipNum;
  logic              recordOrPlay;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic              busy;

  modport master (
    input  btn_record, btn_play, btn_clip, sample_tick,
    output clipNum, recordOrPlay, mem_addr, mem_we, mem_re, busy
  );

  modport slave (
    output btn_record, btn_play, btn_clip, sample_tick,
    input  clipNum, recordOrPlay, mem_addr, mem_we, mem_re, busy
  );
endinterface

// File: rtl/clip_controller.sv
// Two-clip audio record/playback controller: debounced buttons drive an
// IDLE/RECORD/PLAY FSM that strobes sample-memory writes and reads.
module clip_controller #(
  parameter int ADDR_W     = 16,
  parameter int CLIP_WORDS = 32768,
  parameter int DEBOUNCE   = 1000
) (
  input logic               clock,
  input logic               reset,
  clip_controller_if.master bus
);
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [ADDR_W-1:0] OFF_LAST = ADDR_W'(CLIP_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  // Button bit order: [0] record, [1] play, [2] clip
  logic [2:0]       raw_s;
  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  logic [2:0]       level_r;
  logic [2:0]       press_r;
  logic [CNT_W-1:0] cnt_r [3];

  logic rec_ev_s;
  logic play_ev_s;
  logic clip_ev_s;

  state_t            state_r;
  state_t            state_s;
  logic              clip_r;
  logic              clip_s;
  logic              mode_r;
  logic              mode_s;
  logic [ADDR_W-1:0] offset_r;
  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_s;
  logic              we_r;
  logic              we_s;
  logic              re_r;
  logic              re_s;
  logic              busy_r;
  logic              len_we_s;
  logic [ADDR_W-1:0] cur_len_s;
  logic [ADDR_W-1:0] len_r [2];

  assign raw_s     = {bus.btn_clip, bus.btn_play, bus.btn_record};
  assign rec_ev_s  = press_r[0];
  assign play_ev_s = press_r[1];
  assign clip_ev_s = press_r[2];

  // Synchronize, debounce and edge-detect the three buttons
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      level_r <= 3'b000;
      press_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 3; i++) begin
        press_r[i] <= 1'b0;
        if (sync2_r[i] == level_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          // Only an accepted rising level produces an event
          level_r[i] <= sync2_r[i];
          press_r[i] <= sync2_r[i];
          cnt_r[i]   <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_s   = state_r;
    clip_s    = clip_r;
    mode_s    = mode_r;
    offset_s  = offset_r;
    addr_s    = addr_r;
    we_s      = 1'b0;
    re_s      = 1'b0;
    len_we_s  = 1'b0;
    cur_len_s = len_r[clip_r];

    case (state_r)
      IDLE: begin
        if (rec_ev_s) begin
          state_s  = RECORD;
          mode_s   = 1'b0;
          offset_s = '0;
        end else if (play_ev_s && (cur_len_s != '0)) begin
          state_s  = PLAY;
          mode_s   = 1'b1;
          offset_s = '0;
        end else if (clip_ev_s) begin
          clip_s = ~clip_r;
        end else begin
          state_s = IDLE;
        end
      end

      RECORD: begin
        if (bus.sample_tick) begin
          we_s     = 1'b1;
          addr_s   = {clip_r, offset_r[ADDR_W-2:0]};
          offset_s = offset_r + ADDR_W'(1);
        end else begin
          we_s = 1'b0;
        end
        // The tick coinciding with a stop press is still written
        if ((bus.sample_tick && (offset_r == OFF_LAST)) || rec_ev_s) begin
          state_s  = IDLE;
          len_we_s = 1'b1;
        end else begin
          state_s = RECORD;
        end
      end

      PLAY: begin
        if (bus.sample_tick) begin
          re_s     = 1'b1;
          addr_s   = {clip_r, offset_r[ADDR_W-2:0]};
          offset_s = offset_r + ADDR_W'(1);
        end else begin
          re_s = 1'b0;
        end
        if ((bus.sample_tick && (offset_r == (cur_len_s - ADDR_W'(1)))) || play_ev_s) begin
          state_s = IDLE;
        end else begin
          state_s = PLAY;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, registered outputs and per-clip lengths
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      clip_r   <= 1'b0;
      mode_r   <= 1'b0;
      offset_r <= '0;
      addr_r   <= '0;
      we_r     <= 1'b0;
      re_r     <= 1'b0;
      busy_r   <= 1'b0;
      len_r[0] <= '0;
      len_r[1] <= '0;
    end else begin
      state_r  <= state_s;
      clip_r   <= clip_s;
      mode_r   <= mode_s;
      offset_r <= offset_s;
      addr_r   <= addr_s;
      we_r     <= we_s;
      re_r     <= re_s;
      busy_r   <= (state_s != IDLE);
      if (len_we_s) begin
        len_r[clip_r] <= offset_s;
      end
    end
  end

  assign bus.clipNum      = clip_r;
  assign bus.recordOrPlay = mode_r;
  assign bus.mem_addr     = addr_r;
  assign bus.mem_we       = we_r;
  assign bus.mem_re       = re_r;
  assign bus.busy         = busy_r;
endmodule

// File: tb/tb_clip_controller.sv
// Directed bench for clip_controller (ADDR_W=4, CLIP_WORDS=8, DEBOUNCE=4):
// a table of button/tick steps plus hand-written reset and stop-timing sequences.
module tb_clip_controller;
  localparam int ADDR_W     = 4;
  localparam int CLIP_WORDS = 8;
  localparam int DEBOUNCE   = 4;
  localparam int NV         = 18;

  logic clock;
  logic reset;

  clip_controller_if #(.ADDR_W(ADDR_W)) bus_i ();

  clip_controller #(
    .ADDR_W    (ADDR_W),
    .CLIP_WORDS(CLIP_WORDS),
    .DEBOUNCE  (DEBOUNCE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_i.master)
  );

  typedef struct {
    logic [2:0] btn;      // {clip, play, record}
    int         ticks;
    logic       exp_clip;
    logic       exp_mode;
    logic       exp_busy;
    int         exp_we;
    int         exp_re;
    int         exp_first;
    int         exp_last;
  } vec_t;

  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;
  int we_cnt;
  int re_cnt;
  int first_addr;
  int last_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe monitor: count and log addresses, flag simultaneous we/re
  always @(negedge clock) begin
    if (!reset && (bus_i.mem_we || bus_i.mem_re)) begin
      if ((we_cnt + re_cnt) == 0) first_addr = int'(bus_i.mem_addr);
      last_addr = int'(bus_i.mem_addr);
      if (bus_i.mem_we) we_cnt++;
      if (bus_i.mem_re) re_cnt++;
      checks++;
      if (bus_i.mem_we && bus_i.mem_re) begin
        errors++;
        $display("FAIL we_re_exclusive: we=%0b re=%0b required not both 1", bus_i.mem_we, bus_i.mem_re);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    we_cnt     = 0;
    re_cnt     = 0;
    first_addr = 0;
    last_addr  = 0;
  endtask

  task automatic press(input logic [2:0] m);
    @(negedge clock);
    bus_i.btn_record = m[0];
    bus_i.btn_play   = m[1];
    bus_i.btn_clip   = m[2];
    repeat (10) @(negedge clock);
    bus_i.btn_record = 1'b0;
    bus_i.btn_play   = 1'b0;
    bus_i.btn_clip   = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      bus_i.sample_tick = 1'b1;
      @(negedge clock);
      bus_i.sample_tick = 1'b0;
      repeat (2) @(negedge clock);
    end
  endtask

  // Record press whose event cycle coincides with a sample tick
  task automatic stop_rec_with_tick();
    @(negedge clock);
    bus_i.btn_record = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    bus_i.sample_tick = 1'b1;
    @(negedge clock);
    bus_i.sample_tick = 1'b0;
    repeat (8) @(negedge clock);
    bus_i.btn_record = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic chk_status(input string tag, input logic c, input logic m, input logic b);
    chk({tag, "_clipNum"}, int'(bus_i.clipNum), int'(c));
    chk({tag, "_recordOrPlay"}, int'(bus_i.recordOrPlay), int'(m));
    chk({tag, "_busy"}, int'(bus_i.busy), int'(b));
  endtask

  initial begin
    //         btn     tk  clip  mode  busy  we re first last
    tbl[0]  = '{3'b010, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};   // play on empty clip 0
    tbl[1]  = '{3'b001, 0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0};   // start record
    tbl[2]  = '{3'b000, 5, 1'b0, 1'b0, 1'b1, 5, 0, 0, 4};
    tbl[3]  = '{3'b001, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};   // stop record
    tbl[4]  = '{3'b010, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0};   // play clip 0
    tbl[5]  = '{3'b000, 5, 1'b0, 1'b1, 1'b0, 0, 5, 0, 4};   // auto end
    tbl[6]  = '{3'b000, 2, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};   // ticks in IDLE
    tbl[7]  = '{3'b100, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0};   // clip -> 1
    tbl[8]  = '{3'b010, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0};   // play on empty clip 1
    tbl[9]  = '{3'b001, 0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0};
    tbl[10] = '{3'b100, 0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0};   // clip ignored while busy
    tbl[11] = '{3'b000, 10, 1'b1, 1'b0, 1'b0, 8, 0, 8, 15}; // full clip, auto end
    tbl[12] = '{3'b010, 0, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0};
    tbl[13] = '{3'b000, 3, 1'b1, 1'b1, 1'b1, 0, 3, 8, 10};
    tbl[14] = '{3'b010, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0};   // stop play
    tbl[15] = '{3'b100, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
    tbl[16] = '{3'b010, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0};
    tbl[17] = '{3'b000, 5, 1'b0, 1'b1, 1'b0, 0, 5, 0, 4};

    reset             = 1'b1;
    bus_i.btn_record  = 1'b0;
    bus_i.btn_play    = 1'b0;
    bus_i.btn_clip    = 1'b0;
    bus_i.sample_tick = 1'b0;
    clr_mon();
    repeat (2) @(negedge clock);
    chk_status("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_mem_addr", int'(bus_i.mem_addr), 0);
    chk("reset_mem_we", int'(bus_i.mem_we), 0);
    chk("reset_mem_re", int'(bus_i.mem_re), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < NV; i++) begin
      clr_mon();
      if (tbl[i].btn != 3'b000) press(tbl[i].btn);
      ticks(tbl[i].ticks);
      repeat (3) @(negedge clock);
      chk_status($sformatf("vec%0d", i), tbl[i].exp_clip, tbl[i].exp_mode, tbl[i].exp_busy);
      chk($sformatf("vec%0d_we_count", i), we_cnt, tbl[i].exp_we);
      chk($sformatf("vec%0d_re_count", i), re_cnt, tbl[i].exp_re);
      if ((tbl[i].exp_we + tbl[i].exp_re) > 0) begin
        chk($sformatf("vec%0d_first_addr", i), first_addr, tbl[i].exp_first);
        chk($sformatf("vec%0d_last_addr", i), last_addr, tbl[i].exp_last);
      end
    end

    // Short glitch on record: never accepted
    clr_mon();
    @(negedge clock);
    bus_i.btn_record = 1'b1;
    repeat (2) @(negedge clock);
    bus_i.btn_record = 1'b0;
    repeat (20) @(negedge clock);
    chk("glitch_busy", int'(bus_i.busy), 0);
    chk("glitch_we_count", we_cnt, 0);

    // Record+play together -> record; stop press coinciding with a tick
    clr_mon();
    press(3'b011);
    chk_status("both", 1'b0, 1'b0, 1'b1);
    ticks(2);
    stop_rec_with_tick();
    repeat (3) @(negedge clock);
    chk("stoptick_we_count", we_cnt, 3);
    chk("stoptick_last_addr", last_addr, 2);
    chk("stoptick_busy", int'(bus_i.busy), 0);
    clr_mon();
    press(3'b010);
    ticks(4);
    repeat (3) @(negedge clock);
    chk("replay_re_count", re_cnt, 3);
    chk("replay_last_addr", last_addr, 2);
    chk_status("replay", 1'b0, 1'b1, 1'b0);

    // Reset mid-record on clip 1 after three writes
    press(3'b100);
    clr_mon();
    press(3'b001);
    ticks(3);
    chk("prereset_we_count", we_cnt, 3);
    chk("prereset_last_addr", last_addr, 10);
    #2 reset = 1'b1;
    #1;
    chk_status("async_reset", 1'b0, 1'b0, 1'b0);
    chk("async_reset_mem_addr", int'(bus_i.mem_addr), 0);
    chk("async_reset_mem_we", int'(bus_i.mem_we), 0);
    chk("async_reset_mem_re", int'(bus_i.mem_re), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clr_mon();
    press(3'b010);
    ticks(2);
    repeat (3) @(negedge clock);
    chk("postreset_play_busy", int'(bus_i.busy), 0);
    chk("postreset_play_re_count", re_cnt, 0);
    chk("postreset_recordOrPlay", int'(bus_i.recordOrPlay), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
